// File: rtl/sha256_ctx_arbiter.sv
// Shares one sha256 core between NUM_REQ requesters: round-robin context grant plus an in-order
// tag FIFO that routes returning hashes. Define SHA256_ARB_FIXED_PRIO_EN for fixed lowest-index priority.
package sha256_pkg;
   typedef struct packed {
      logic [255:0] digest;
      logic [511:0] block;
   } ShaContext;
endpackage

module sha256_ctx_arbiter
   import sha256_pkg::*;
#(
   parameter  int NUM_REQ         = 4,
   parameter  int MAX_OUTSTANDING = 8,
   localparam int IW              = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1,
   localparam int PW              = $clog2(MAX_OUTSTANDING),
   localparam int CW              = $clog2(MAX_OUTSTANDING + 1)
) (
   input  logic                              clk,
   input  logic                              rst,
   input  logic      [NUM_REQ-1:0]           req_ctx_vld,
   output logic      [NUM_REQ-1:0]           req_ctx_rdy,
   input  ShaContext [NUM_REQ-1:0]           req_ctx,
   output logic                              core_ctx_vld,
   input  logic                              core_ctx_rdy,
   output ShaContext                         core_ctx,
   input  logic                              core_hash_vld,
   output logic                              core_hash_rdy,
   input  logic      [255:0]                 core_hash,
   output logic      [NUM_REQ-1:0]           rsp_hash_vld,
   input  logic      [NUM_REQ-1:0]           rsp_hash_rdy,
   output logic      [255:0]                 rsp_hash,
   output logic      [CW-1:0]                outstanding,
   output logic                              orphan_err
);

   logic [IW-1:0] tag_mem [MAX_OUTSTANDING];
   logic [PW-1:0] wr_ptr, rd_ptr;
   logic [IW-1:0] g, head;
   logic          load, pop, full, empty;

`ifndef SHA256_ARB_FIXED_PRIO_EN
   logic [IW-1:0] rr_ptr;
`endif

   // Descending scan so the last hit is the first requester in search order.
   always_comb begin
      g = '0;
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
`ifdef SHA256_ARB_FIXED_PRIO_EN
         if (req_ctx_vld[k]) g = IW'(k);
`else
         if (req_ctx_vld[(int'(rr_ptr) + k) % NUM_REQ]) g = IW'((int'(rr_ptr) + k) % NUM_REQ);
`endif
      end
   end

   assign full  = (outstanding == CW'(MAX_OUTSTANDING));
   assign empty = (outstanding == '0);
   assign load  = !rst && (!core_ctx_vld || core_ctx_rdy) && !full && (|req_ctx_vld);
   assign req_ctx_rdy = load ? (NUM_REQ'(1) << g) : '0;

   assign head          = tag_mem[rd_ptr];
   assign rsp_hash      = core_hash;
   assign rsp_hash_vld  = (core_hash_vld && !empty) ? (NUM_REQ'(1) << head) : '0;
   // With no tag outstanding the hash is swallowed so the core never hangs on it.
   assign core_hash_rdy = empty ? core_hash_vld : rsp_hash_rdy[head];
   assign pop           = core_hash_vld && core_hash_rdy && !empty;

   always_ff @(posedge clk) begin
      if (load) tag_mem[wr_ptr] <= g;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         core_ctx_vld <= 1'b0;
         core_ctx     <= '0;
         wr_ptr       <= '0;
         rd_ptr       <= '0;
         outstanding  <= '0;
         orphan_err   <= 1'b0;
      end else begin
         if (load) begin
            core_ctx     <= req_ctx[g];
            core_ctx_vld <= 1'b1;
            wr_ptr       <= wr_ptr + PW'(1);
         end else if (core_ctx_rdy) begin
            core_ctx_vld <= 1'b0;
         end
         if (pop) rd_ptr <= rd_ptr + PW'(1);
         case ({load, pop})
            2'b10:   outstanding <= outstanding + CW'(1);
            2'b01:   outstanding <= outstanding - CW'(1);
            default: outstanding <= outstanding;
         endcase
         if (core_hash_vld && empty) orphan_err <= 1'b1;
      end
   end

`ifndef SHA256_ARB_FIXED_PRIO_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst)       rr_ptr <= '0;
      else if (load) rr_ptr <= (g == IW'(NUM_REQ - 1)) ? '0 : g + IW'(1);
   end
`endif

endmodule
